mem_bus_responder: RTL
======================

// Module: mem_bus_responder
// PURPOSE
//  Bus-side memory target answering the requests issued by the CPU memory manager on the shared addr/data bus.
//  Queues read_q/write_q requests, accesses a word-organised internal RAM after a programmable latency,
//  then owns the bus for one cycle to return addr/data with read_dn or write_dn.
//  Sits between the CPU register/memory manager and the backing store; lets the manager fire cond/src1/src0 reads back-to-back.
// PARAMETERS
//  ADDR_W      32   address width (byte addresses)
//  DATA_W      32   data width; word stride = DATA_W/8 bytes
//  MEM_WORDS   256  internal RAM depth in words
//  FIFO_DEPTH  4    request queue depth (power of 2)
//  READ_LAT    2    cycles from dequeue to response, >=1 (reads and writes)
// PORTS
//  clk          in     1       clock, all logic on posedge
//  rst          in     1       synchronous, active-low reset
//  is_bus_busy  inout  1       driven 1 only in RESP, else Z
//  addr         inout  ADDR_W  sampled on request; driven with request addr in RESP, else Z
//  data         inout  DATA_W  write data sampled on write_q; read data driven in RESP, else Z
//  read_q       in     1       read request strobe (one cycle)
//  write_q      in     1       write request strobe (one cycle)
//  read_dn      out    1       read response strobe, high only in RESP of a read
//  write_dn     out    1       write completion strobe, high only in RESP of a write
//  fifo_level   out    log2(FIFO_DEPTH)+1  queued requests
//  ovf_err      out    1       sticky: request dropped, queue full
//  addr_err     out    1       sticky: word index >= MEM_WORDS
//  proto_err    out    1       sticky: read_q and write_q in the same cycle
// BEHAVIOUR
//  Reset (rst==0 at posedge): FSM=IDLE, queue flushed, fifo_level=0, read_dn=write_dn=0, bus lines Z, all err flags 0.
//   RAM contents are not cleared. Reset mid-WAIT/RESP aborts the pending response; no strobe is issued.
//  Capture: a strobe is sampled on every posedge except in RESP. Push {op, addr, data if write}.
//   word index = addr[ADDR_W-1:log2(DATA_W/8)]; the low byte bits are ignored.
//   read_q&write_q together: write is pushed, read dropped, proto_err=1.
//   queue full: request dropped, ovf_err=1, fifo_level stays FIFO_DEPTH.
//   A push and a pop in the same cycle are allowed; the level is unchanged.
//  FSM:
//   IDLE: queue non-empty -> pop head, cnt=READ_LAT-1, go to WAIT; else stay in IDLE.
//   WAIT: cnt!=0 -> cnt-- ; cnt==0 -> go to RESP. Pop in cycle N gives RESP in cycle N+READ_LAT.
//   RESP: one cycle. is_bus_busy=1, addr=request addr.
//     read: data=mem[idx], read_dn=1.
//     write: mem[idx]<=captured data, write_dn=1, data stays Z.
//     -> TURN.
//   TURN: one cycle. All bus lines Z, strobes 0 (bus turnaround) -> IDLE.
//  Ordering: responses are strictly FIFO. Throughput is one response per READ_LAT+2 cycles.
//  Out of range (idx>=MEM_WORDS): a read returns data=0 with a normal read_dn; a write is discarded with a normal write_dn.
//   addr_err=1 in both cases.
//  Err flags clear only on reset.
// TESTING
//  1 write_q addr=0x10 data=0xDEADBEEF, then read_q addr=0x10 -> write_dn, then read_dn with addr=0x10 data=0xDEADBEEF.
//  2 RAM[0..2]=0x11,0x22,0x33; read_q 0x0,0x4,0x8 on 3 consecutive cycles -> 3 read_dn in order.
//    Each read_dn has its own addr/data and TURN cycles between them; no bus contention (X).
//  3 READ_LAT=8, read_q on 6 consecutive cycles -> 6th request dropped, ovf_err=1, exactly 5 read_dn.
//  4 read_q addr=MEM_WORDS*4 -> read_dn with data=0, addr_err=1; RAM unchanged.
//  5 read_q&write_q together (addr 0x8, data 0x5A) -> proto_err=1, only write_dn; later read of 0x8 returns 0x5A.
//  6 rst=0 during WAIT -> no read_dn/write_dn; next cycle bus lines Z, fifo_level=0, flags 0.

Source files
------------

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: queued memory target on a shared tri-state addr/data bus.
// Requests are captured into a small FIFO. Each request is served after a
// programmable latency by owning the bus for one cycle. A turnaround cycle
// follows every response.
module mem_bus_responder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_WORDS  = 256,
    parameter int FIFO_DEPTH = 4,
    parameter int READ_LAT   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    inout  wire                         is_bus_busy,
    inout  wire  [ADDR_W-1:0]           addr,
    inout  wire  [DATA_W-1:0]           data,
    input  logic                        read_q,
    input  logic                        write_q,
    output logic                        read_dn,
    output logic                        write_dn,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        ovf_err,
    output logic                        addr_err,
    output logic                        proto_err
);

    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam int IDX_W  = ADDR_W - BYTE_W;
    localparam int MEM_AW = $clog2(MEM_WORDS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int CNT_W  = $clog2(READ_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, TURN} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    // request queue storage
    logic               q_op   [FIFO_DEPTH];
    logic [ADDR_W-1:0]  q_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]  q_data [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level;

    // request currently being served (op: 1 = write)
    logic               cur_op;
    logic [ADDR_W-1:0]  cur_addr;
    logic [DATA_W-1:0]  cur_data;

    logic [DATA_W-1:0]  mem [MEM_WORDS];

    logic               capture, req, full, push, pop, drive;
    logic [IDX_W-1:0]   cur_idx;
    logic [MEM_AW-1:0]  mem_idx;
    logic               in_range;
    logic [DATA_W-1:0]  rd_word;

    // Requests are ignored while we own the bus; a full queue drops new requests.
    always_comb begin
        capture = (state != RESP);
        req     = capture && (read_q || write_q);
        full    = (level == LVL_W'(FIFO_DEPTH));
        push    = req && !full;
        pop     = (state == IDLE) && (level != '0);
    end

    // Word decode of the request being served; out-of-range reads return zero.
    always_comb begin
        cur_idx  = cur_addr[ADDR_W-1:BYTE_W];
        in_range = (cur_idx < IDX_W'(MEM_WORDS));
        mem_idx  = cur_idx[MEM_AW-1:0];
        rd_word  = in_range ? mem[mem_idx] : '0;
    end

    // Next-state logic. cnt holds the remaining WAIT cycles so that a pop in
    // cycle N lands in RESP in cycle N+READ_LAT.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (pop) begin
                    if (READ_LAT == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(READ_LAT - 1);
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = TURN;
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Queue pointers and occupancy; simultaneous push and pop keep the level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Queue payload; a simultaneous read strobe is dropped in favour of the write.
    always_ff @(posedge clk) begin
        if (push) begin
            q_op[wr_ptr]   <= write_q;
            q_addr[wr_ptr] <= addr;
            q_data[wr_ptr] <= data;
        end
    end

    // Latch the queue head when it is popped.
    always_ff @(posedge clk) begin
        if (pop) begin
            cur_op   <= q_op[rd_ptr];
            cur_addr <= q_addr[rd_ptr];
            cur_data <= q_data[rd_ptr];
        end
    end

    // RAM write at the response cycle; a reset in that cycle aborts it.
    always_ff @(posedge clk) begin
        if (rst && state == RESP && cur_op && in_range) begin
            mem[mem_idx] <= cur_data;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_err   <= 1'b0;
            addr_err  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (req && full)                        ovf_err   <= 1'b1;
            if (capture && read_q && write_q)       proto_err <= 1'b1;
            if (state == RESP && !in_range)         addr_err  <= 1'b1;
        end
    end

    // Response strobes and bus ownership, decoded from the state register.
    always_comb begin
        drive    = (state == RESP);
        read_dn  = drive && !cur_op;
        write_dn = drive && cur_op;
    end

    assign fifo_level  = level;
    assign is_bus_busy = drive ? 1'b1 : 1'bz;
    assign addr        = drive ? cur_addr : {ADDR_W{1'bz}};
    assign data        = (drive && !cur_op) ? rd_word : {DATA_W{1'bz}};

endmodule
